// File: rtl/byte_assembler_pkg.sv
// Shared constants and types for the serial byte assembler.
//   BYTE_W         : width of an assembled byte
//   BITS_PER_FRAME : serial bits between frame strobes
//   BC_W           : width of the saturating bit counter (0..BITS_PER_FRAME)
//   state_t        : framing FSM states
package assembler_pkg;
    localparam int BYTE_W         = 8;
    localparam int BITS_PER_FRAME = 8;
    localparam int BC_W           = $clog2(BITS_PER_FRAME + 1);

    typedef enum logic {SYNC, RUN} state_t;
endpackage

// File: rtl/byte_assembler_if.sv
// Output byte stream with a valid/ready handshake.
//   m_data  : head-of-queue byte
//   m_valid : a byte is available
//   m_ready : consumer accepts m_data when m_valid && m_ready
// master = producer (assembler), slave = consumer.
interface byte_assembler_if;
    import assembler_pkg::*;

    logic [BYTE_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/byte_assembler_fifo.sv
// Synchronous FIFO for assembled bytes, drop-on-full.
//   push/wdata : write request; ignored (and drop pulsed) when full with no pop
//   pop        : read request; ignored when empty
//   rdata      : head entry, zero while empty
//   full/empty : occupancy flags
//   level      : occupancy 0..DEPTH (pointer difference with one extra bit)
//   drop       : combinational pulse when a push is discarded
module byte_fifo #(
    parameter int DEPTH  = 4,
    parameter int BYTE_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [BYTE_W-1:0]       wdata,
    input  logic                    pop,
    output logic [BYTE_W-1:0]       rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW:0]       wr, rd;
    logic              pop_ok, push_ok;

    assign level   = wr - rd;
    assign empty   = (wr == rd);
    assign full    = (level == FULL_LVL);
    assign pop_ok  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & full & ~pop_ok;
    assign rdata   = empty ? '0 : mem[rd[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr <= '0;
            rd <= '0;
        end else begin
            if (push_ok) wr <= wr + PTR_ONE;
            if (pop_ok)  rd <= rd + PTR_ONE;
        end
    end

    // Storage needs no reset: rdata is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/byte_assembler.sv
// Serial-to-parallel byte assembler framed by an external mod-8 strobe.
//   clk, reset : clock, synchronous active-high reset
//   sin        : serial bit, MSB first, sampled every clock
//   dv         : strobe marking the current bit as the last of a byte
//   m          : byte stream out (valid/ready), see byte_assembler_if
//   level      : output queue occupancy 0..DEPTH
//   synced     : framing FSM is locked (RUN)
//   frame_err  : one-cycle pulse after a short frame or a missing strobe
//   overflow   : sticky, a byte was dropped because the queue was full
module byte_assembler
    import assembler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sin,
    input  logic                    dv,
    byte_assembler_if.master        m,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    synced,
    output logic                    frame_err,
    output logic                    overflow
);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BITS_PER_FRAME - 1);
    localparam logic [BC_W-1:0] BC_MAX  = BC_W'(BITS_PER_FRAME);

    state_t            state_q, state_d;
    logic [BYTE_W-1:0] sh;
    logic [BC_W-1:0]   bc;
    logic [BYTE_W-1:0] byte_in;
    logic              push, err_d, drop, full, empty;

    // The strobe bit completes the byte in the same cycle it is sampled.
    assign byte_in = {sh[BYTE_W-2:0], sin};

    always_ff @(posedge clk) begin
        if (reset) begin
            sh        <= '0;
            bc        <= '0;
            state_q   <= SYNC;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            sh        <= byte_in;
            state_q   <= state_d;
            frame_err <= err_d;
            overflow  <= overflow | drop;
            if (dv)                bc <= '0;
            else if (bc != BC_MAX) bc <= bc + BC_W'(1);
        end
    end

    // bc counts bits already taken since the last strobe, so bc==7 on a
    // strobe means the current bit is the 8th; bc==8 without one is the 9th.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            SYNC: begin
                if (dv) state_d = RUN;
            end
            RUN: begin
                if (dv) begin
                    if (bc == BC_LAST) push  = 1'b1;
                    else               err_d = 1'b1;
                end else if (bc == BC_MAX) begin
                    err_d   = 1'b1;
                    state_d = SYNC;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    assign synced = (state_q == RUN);

    byte_fifo #(.DEPTH(DEPTH), .BYTE_W(BYTE_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (byte_in),
        .pop   (m.m_ready),
        .rdata (m.m_data),
        .full  (full),
        .empty (empty),
        .level (level),
        .drop  (drop)
    );

    assign m.m_valid = ~empty;
endmodule

// File: tb/tb_byte_assembler.sv
module tb_byte_assembler;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sin = 1'b0;
    logic       dv = 1'b0;
    logic [2:0] level;
    logic       synced, frame_err, overflow;
    logic       first_fe;
    logic       chk_lvl = 1'b0;
    int         n_assert = 0;
    int         n_fail = 0;

    byte_assembler_if bus ();

    byte_assembler #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .sin       (sin),
        .dv        (dv),
        .m         (bus),
        .level     (level),
        .synced    (synced),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one serial bit; returns 1 time unit after the sampling edge.
    task automatic step(input logic s, input logic d);
        sin = s;
        dv  = d;
        @(posedge clk);
        #1;
    endtask

    // Send a byte MSB first with dv on the last bit. r0 is m_ready for the
    // first bit (to drain a previously delivered byte), r for the rest.
    task automatic send_byte(input logic [7:0] b, input logic r0, input logic r);
        for (int i = 7; i >= 0; i--) begin
            bus.m_ready = (i == 7) ? r0 : r;
            step(b[i], i == 0);
            if (i == 7) first_fe = frame_err;
            if (chk_lvl) chk("level_le1", {31'd0, level <= 3'd1}, 32'd1);
        end
    endtask

    initial begin
        bus.m_ready = 1'b0;
        first_fe    = 1'b0;
        step(0, 0);
        step(0, 0);
        reset = 1'b0;
        chk("rst_level", level, 0);
        chk("rst_valid", bus.m_valid, 0);
        chk("rst_data", bus.m_data, 0);
        chk("rst_synced", synced, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovf", overflow, 0);

        // partial frame, strobe on the 3rd bit
        step(1, 0);
        step(0, 0);
        step(1, 1);
        chk("sync_synced", synced, 1);
        chk("sync_nopush", bus.m_valid, 0);
        chk("sync_ferr", frame_err, 0);

        send_byte(8'hA5, 1, 1);
        chk("a5_valid", bus.m_valid, 1);
        chk("a5_data", bus.m_data, 8'hA5);

        // stream, consumer always ready
        chk_lvl = 1'b1;
        send_byte(8'h01, 1, 1);
        chk("s01_data", bus.m_data, 8'h01);
        chk("s01_level", level, 1);
        send_byte(8'h80, 1, 1);
        chk("s80_data", bus.m_data, 8'h80);
        send_byte(8'hFF, 1, 1);
        chk("sff_data", bus.m_data, 8'hFF);
        send_byte(8'h3C, 1, 1);
        chk("s3c_data", bus.m_data, 8'h3C);
        chk("s3c_valid", bus.m_valid, 1);
        chk("stream_ovf", overflow, 0);
        chk_lvl = 1'b0;

        // back-pressure
        send_byte(8'h10, 1, 0);
        chk("bp1_level", level, 1);
        chk("bp1_data", bus.m_data, 8'h10);
        send_byte(8'h11, 0, 0);
        chk("bp2_level", level, 2);
        send_byte(8'h12, 0, 0);
        chk("bp3_level", level, 3);
        send_byte(8'h13, 0, 0);
        chk("bp4_level", level, 4);
        chk("bp4_ovf", overflow, 0);
        send_byte(8'h14, 0, 0);
        chk("bp5_level", level, 4);
        chk("bp5_ovf", overflow, 1);
        chk("bp5_data_stable", bus.m_data, 8'h10);
        bus.m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("pop_data", bus.m_data, 32'h10 + k);
            step(0, 0);
        end
        chk("pop_empty", bus.m_valid, 0);
        chk("pop_level", level, 0);
        chk("pop_ovf_sticky", overflow, 1);

        // short frame: strobe on the 5th bit since the last strobe
        step(0, 1);
        chk("short_ferr", frame_err, 1);
        chk("short_nopush", level, 0);
        chk("short_synced", synced, 1);
        send_byte(8'h5A, 1, 1);
        chk("short_ferr_pulse", first_fe, 0);
        chk("s5a_valid", bus.m_valid, 1);
        chk("s5a_data", bus.m_data, 8'h5A);

        // missing strobe: 9 bits without dv
        for (int k = 1; k <= 9; k++) begin
            step(0, 0);
            if (k == 8) begin
                chk("miss8_ferr", frame_err, 0);
                chk("miss8_synced", synced, 1);
            end
        end
        chk("miss_ferr", frame_err, 1);
        chk("miss_synced", synced, 0);
        step(0, 1);
        chk("resync_ferr", frame_err, 0);
        chk("resync_synced", synced, 1);
        chk("resync_nopush", bus.m_valid, 0);
        send_byte(8'hC3, 1, 1);
        chk("sc3_data", bus.m_data, 8'hC3);
        chk("sc3_valid", bus.m_valid, 1);

        // reset with 3 bytes queued and a half-shifted frame
        send_byte(8'h21, 1, 0);
        send_byte(8'h22, 0, 0);
        send_byte(8'h23, 0, 0);
        chk("pre_rst_level", level, 3);
        step(0, 0);
        step(0, 0);
        step(1, 0);
        step(0, 0);
        reset = 1'b1;
        step(0, 0);
        reset = 1'b0;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_valid", bus.m_valid, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_synced", synced, 0);
        chk("mid_rst_data", bus.m_data, 0);
        send_byte(8'h77, 0, 0);
        chk("post_rst_nopush", bus.m_valid, 0);
        chk("post_rst_synced", synced, 1);
        send_byte(8'h99, 0, 0);
        chk("post_rst_valid", bus.m_valid, 1);
        chk("post_rst_data", bus.m_data, 8'h99);
        chk("post_rst_level", level, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/byte_assembler.md
# byte_assembler

Serial-to-parallel stage downstream of the mod-8 frame counter. It shifts in one serial bit per clock and uses the counter's one-cycle `dv` strobe as the byte boundary. Each complete 8-bit frame is pushed into a small output FIFO and presented to the next stage on a valid/ready handshake. Framing errors and FIFO overflow are reported.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `sin` in 1: serial data bit, sampled every clock, MSB first.
- `dv` in 1: frame strobe from mod-8 counter; high means the bit sampled on this edge is bit 0 (last) of a byte.
- `m_data` out 8: head-of-FIFO byte.
- `m_valid` out 1: FIFO non-empty.
- `m_ready` in 1: consumer accepts `m_data` when `m_valid && m_ready`.
- `level` out $clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH.
- `synced` out 1: high while the FSM is in RUN.
- `frame_err` out 1: one-cycle pulse on a framing error.
- `overflow` out 1: sticky; set when a byte is dropped because the FIFO is full; cleared only by `reset`.

## Operation
- Shift register: `sh <= {sh[6:0], sin}` every clock. Assembled byte on strobe is `{sh[6:0], sin}`.
- Bit counter `bc` (0..8, saturating) counts bits since the last strobe. It clears to 0 on strobe.
- FSM states:
  - SYNC (reset state):
    - `dv` → RUN; no byte emitted. The partial first frame is discarded.
  - RUN:
    - `dv` with `bc==7` (this is the 8th bit) → push byte.
    - `dv` with `bc<7` → pulse `frame_err`, discard the byte, stay in RUN, clear `bc`.
    - No `dv` and `bc` reaches 8 (9th bit without strobe) → pulse `frame_err`, go to SYNC.
- FIFO push when `dv` qualifies in RUN. Pop when `m_valid && m_ready`.
- Push while full with no pop in the same cycle → byte dropped, `overflow` set.
- Push and pop in the same cycle when full → both happen; `level` stays at DEPTH; no overflow.
- Push and pop in the same cycle when empty → push only (the pop is not valid); `level` becomes 1.
- Read/write pointers wrap modulo DEPTH. `level` = wr − rd, using one extra pointer bit.
- Reset values: `sh`=0, `bc`=0, state SYNC, `level`=0, `m_valid`=0, `m_data`=0, `synced`=0, `frame_err`=0, `overflow`=0.
- Reset mid-frame or with the FIFO non-empty: all contents are discarded; the block resynchronises on the next `dv`.

## Timing
- Byte latency: the strobe edge writes the FIFO; `m_valid`/`m_data` update on that same edge's output. The byte is visible the cycle after `dv` is sampled.
- `m_data` is stable while `m_valid && !m_ready`.
- `frame_err` is high for exactly the cycle after the offending edge.
- `synced` rises the cycle after the first `dv` following reset.
- Steady state with a mod-8 strobe: one push every 8 clocks. A consumer holding `m_ready=0` fills a DEPTH=4 FIFO after 4 frames (32 clocks). The 5th byte overflows.

## Structure
- Package `assembler_pkg`:
  - `BYTE_W=8`
  - `BITS_PER_FRAME=8`
  - state enum `{SYNC, RUN}`
- Sub-module `byte_fifo`:
  - parameterised synchronous FIFO (`DEPTH`, `BYTE_W`)
  - push/pop/full/empty/level
  - drop-on-full, with a `drop` output that feeds the sticky `overflow`.
- Top level holds the shift register, bit counter and FSM.

## Test plan
- **Reset, then first frame:** after `reset`, drive `dv` at cycle 3 (partial frame), then every 8 clocks. Serial data is 0xA5 MSB-first after the first strobe.
  - No push on the first strobe.
  - `synced`=1.
  - `m_data`=0xA5, `m_valid`=1 one cycle after the second strobe.
- **Stream with consumer always ready:** send 0x01, 0x80, 0xFF, 0x3C with `m_ready`=1.
  - Each byte appears in order, 1 cycle after its strobe.
  - `level` never exceeds 1.
  - `overflow`=0.
- **Back-pressure:** `m_ready`=0, send 5 bytes (0x10–0x14).
  - `level`=4 after the 4th byte.
  - The 5th byte is dropped and `overflow`=1.
  - Then `m_ready`=1: pops yield 0x10, 0x11, 0x12, 0x13; `overflow` stays 1.
- **Short frame:** in RUN, strobe after 5 bits.
  - `frame_err` is a 1-cycle pulse.
  - No push.
  - `synced` stays 1.
  - The next 8-bit frame 0x5A is delivered correctly.
- **Missing strobe:** in RUN, withhold `dv` for 9 bits.
  - `frame_err` pulses.
  - `synced`=0.
  - The next `dv` resyncs without a push; the following frame is delivered.
- **Reset mid-operation:** FIFO holds 3 bytes and a frame is half shifted; assert `reset` for 1 cycle.
  - `level`=0, `m_valid`=0, `overflow`=0, `synced`=0 on the next cycle.
  - Pushes resume only after resync.
